// File: rtl/sum_sq_driver_if.sv
// Accumulator-side bus between the frame driver and a sum-of-squares unit.
// Ports: a/valid_in/acc_clr toward the accumulator, f/valid_out back.
interface sum_sq_driver_if;
  logic [7:0]  a;
  logic        valid_in;
  logic        acc_clr;
  logic [19:0] f;
  logic        valid_out;

  modport master (
    output a, valid_in, acc_clr,
    input  f, valid_out
  );

  modport slave (
    input  a, valid_in, acc_clr,
    output f, valid_out
  );
endinterface

// File: rtl/sum_sq_driver.sv
// Buffers samples in a FIFO and streams frames into a sum-of-squares unit.
// Ports: clk/reset, s_* FIFO write side, frame_len/start/busy, acc bus, result/err.
module sum_sq_driver #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       s_data,
  input  logic             s_wr,
  output logic             s_full,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             start,
  output logic             busy,
  sum_sq_driver_if.master  acc,
  output logic [19:0]      result,
  output logic             result_valid,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, SEND, WAIT, DONE
  } state_t;

  logic [7:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] sent_q, sent_d;
  logic [LEN_W-1:0] rcvd_q, rcvd_d;
  logic [3:0]      timer_q, timer_d;
  logic [7:0]      a_q, a_d;
  logic            valid_in_q, valid_in_d;
  logic            acc_clr_q, acc_clr_d;
  logic [19:0]     result_q, result_d;
  logic            result_valid_q, result_valid_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic push, pop, empty;

  assign s_full = (count_q == CNT_FULL);
  assign empty  = (count_q == '0);
  assign push   = s_wr && !s_full;

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    sent_d         = sent_q;
    rcvd_d         = rcvd_q;
    timer_d        = timer_q;
    a_d            = a_q;
    valid_in_d     = 1'b0;
    acc_clr_d      = 1'b0;
    result_d       = result_q;
    result_valid_d = 1'b0;
    err_d          = 1'b0;
    pop            = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && frame_len != '0) begin
          len_d     = frame_len;
          acc_clr_d = 1'b1;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        sent_d  = '0;
        rcvd_d  = '0;
        timer_d = '0;
        state_d = SEND;
      end
      SEND: begin
        if (acc.valid_out)
          rcvd_d = rcvd_q + LEN_ONE;
        if (!empty && sent_q < len_q) begin
          pop        = 1'b1;
          a_d        = mem[rd_ptr_q];
          valid_in_d = 1'b1;
          sent_d     = sent_q + LEN_ONE;
          if (sent_d == len_q) begin
            timer_d = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (acc.valid_out) begin
          rcvd_d  = rcvd_q + LEN_ONE;
          timer_d = '0;
          if (rcvd_d == len_q) begin
            result_d       = acc.f;
            result_valid_d = 1'b1;
            state_d        = DONE;
          end
        end else if (timer_q == 4'd15) begin
          // 16th silent cycle: give up on this frame
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push)
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)
      count_d = count_q + CNT_ONE;
    else if (pop && !push)
      count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      len_q          <= '0;
      sent_q         <= '0;
      rcvd_q         <= '0;
      timer_q        <= '0;
      a_q            <= '0;
      valid_in_q     <= 1'b0;
      acc_clr_q      <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      len_q          <= len_d;
      sent_q         <= sent_d;
      rcvd_q         <= rcvd_d;
      timer_q        <= timer_d;
      a_q            <= a_d;
      valid_in_q     <= valid_in_d;
      acc_clr_q      <= acc_clr_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
    end
  end

  assign acc.a        = a_q;
  assign acc.valid_in = valid_in_q;
  assign acc.acc_clr  = acc_clr_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;
  assign busy         = busy_q;

endmodule
